// File: rtl/alu_pkg.sv
// Shared op codes and FSM state encoding for the multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Shared shift datapath for unsigned multiply (shift-add) and restoring divide, one bit per cycle.
// o_hi/o_lo present the value the registers take at the next edge; the top captures them when o_step_done=1.
module alu_muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_mode,   // 0 = multiply, 1 = divide
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_step_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic             r_mode;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opd;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_mul_hi;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_fits;

  // Multiply: accumulator in r_hi, multiplier shifts out of r_lo as product bits shift in.
  assign w_sum    = {1'b0, r_hi} + {1'b0, r_opd};
  assign w_mul_hi = r_lo[0] ? w_sum : {1'b0, r_hi};

  // Divide: remainder in r_hi, dividend shifts out of r_lo as quotient bits shift in.
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_diff  = {1'b0, w_shift} - {2'b00, r_opd};
  assign w_fits  = ~w_diff[WIDTH+1];

  always_comb begin
    o_hi = r_hi;
    o_lo = r_lo;
    if (r_mode) begin
      o_hi = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
      o_lo = {r_lo[WIDTH-2:0], w_fits};
    end else begin
      o_hi = w_mul_hi[WIDTH:1];
      o_lo = {w_mul_hi[0], r_lo[WIDTH-1:1]};
    end
  end

  assign o_step_done = (r_cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= 1'b0;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_opd  <= '0;
    end else if (i_load) begin
      r_mode <= i_mode;
      r_cnt  <= CNT_W'(WIDTH);
      r_hi   <= '0;
      r_lo   <= i_a;
      r_opd  <= i_b;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
      r_hi  <= o_hi;
      r_lo  <= o_lo;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Integer ALU: single-cycle logic/add/compare ops plus iterative MULU/DIVU behind start/busy/done.
// Handshake: an op is accepted on a rising edge with start=1 and busy=0; done pulses once per accepted op.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             cout,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             illegal,
  output logic             busy,
  output logic             done,
  output state_t           dbg_state
);

  state_t           r_state;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic             r_zero;
  logic             r_cout;
  logic             r_ovf;
  logic             r_dbz;
  logic             r_illegal;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_load;
  logic             w_step_done;
  logic [WIDTH-1:0] w_it_hi;
  logic [WIDTH-1:0] w_it_lo;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic [WIDTH-1:0] w_sc_lo;
  logic             w_sc_cout;
  logic             w_sc_ovf;
  logic             w_sc_illegal;

  assign w_accept = start && !r_busy;
  assign w_load   = w_accept && ((op == OP_MULU) || ((op == OP_DIVU) && (b != '0)));

  alu_muldiv_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_mode     (op == OP_DIVU),
    .i_a        (a),
    .i_b        (b),
    .o_step_done(w_step_done),
    .o_hi       (w_it_hi),
    .o_lo       (w_it_lo)
  );

  assign w_add     = {1'b0, a} + {1'b0, b};
  assign w_sub     = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign w_add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
  assign w_sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    w_sc_lo      = '0;
    w_sc_cout    = 1'b0;
    w_sc_ovf     = 1'b0;
    w_sc_illegal = 1'b0;
    case (op)
      OP_AND: w_sc_lo = a & b;
      OP_OR:  w_sc_lo = a | b;
      OP_NOR: w_sc_lo = ~(a | b);
      OP_ADD: begin
        w_sc_lo   = w_add[WIDTH-1:0];
        w_sc_cout = w_add[WIDTH];
        w_sc_ovf  = w_add_ovf;
      end
      OP_SUB: begin
        w_sc_lo   = w_sub[WIDTH-1:0];
        w_sc_cout = w_sub[WIDTH];
        w_sc_ovf  = w_sub_ovf;
      end
      OP_SLT: w_sc_lo = {{(WIDTH-1){1'b0}}, w_sub[WIDTH-1] ^ w_sub_ovf};
      default: w_sc_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_lo      <= '0;
      r_hi      <= '0;
      r_zero    <= 1'b0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
      r_dbz     <= 1'b0;
      r_illegal <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cout    <= 1'b0;
            r_ovf     <= 1'b0;
            r_dbz     <= 1'b0;
            r_illegal <= 1'b0;
            if (op == OP_MULU) begin
              r_state <= ST_MUL;
              r_busy  <= 1'b1;
            end else if (op == OP_DIVU) begin
              if (b == '0) begin
                r_lo   <= '1;
                r_hi   <= a;
                r_zero <= 1'b0;
                r_dbz  <= 1'b1;
                r_done <= 1'b1;
              end else begin
                r_state <= ST_DIV;
                r_busy  <= 1'b1;
              end
            end else begin
              r_lo      <= w_sc_lo;
              r_hi      <= '0;
              r_zero    <= (w_sc_lo == '0);
              r_cout    <= w_sc_cout;
              r_ovf     <= w_sc_ovf;
              r_illegal <= w_sc_illegal;
              r_done    <= 1'b1;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          // Result ports keep the previous op's values until the last step lands.
          if (w_step_done) begin
            r_lo    <= w_it_lo;
            r_hi    <= w_it_hi;
            r_zero  <= (w_it_lo == '0);
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign result_lo   = r_lo;
  assign result_hi   = r_hi;
  assign zero        = r_zero;
  assign cout        = r_cout;
  assign overflow    = r_ovf;
  assign div_by_zero = r_dbz;
  assign illegal     = r_illegal;
  assign busy        = r_busy;
  assign done        = r_done;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle (WIDTH=32) with hand-computed expected values.
module tb_alu_multicycle;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result_lo;
  logic [W-1:0] result_hi;
  logic         zero;
  logic         cout;
  logic         overflow;
  logic         div_by_zero;
  logic         illegal;
  logic         busy;
  logic         done;
  logic [1:0]   dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int lat;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .result_lo  (result_lo),
    .result_hi  (result_hi),
    .zero       (zero),
    .cout       (cout),
    .overflow   (overflow),
    .div_by_zero(div_by_zero),
    .illegal    (illegal),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {zero, cout, overflow, div_by_zero, illegal, busy, done}
  function automatic logic [6:0] flags();
    return {zero, cout, overflow, div_by_zero, illegal, busy, done};
  endfunction

  // Present one request for one edge; returns 1 ns after that edge.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts cycles until done; optionally pulses an ADD start on cycle inject_at.
  task automatic wait_done(input int inject_at, output int cycles);
    cycles = 0;
    while (!done && cycles < 100) begin
      if (cycles == inject_at) begin
        start = 1'b1;
        op    = 4'b0010;
        a     = 32'd2;
        b     = 32'd3;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      cycles++;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: no done within %0d cycles", cycles);
    end
  endtask

  task automatic single(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] exp_lo,
                        input logic [W-1:0] exp_hi, input logic [6:0] exp_fl);
    issue(o, x, y);
    chk({tag, "_lo"}, 64'(result_lo), 64'(exp_lo));
    chk({tag, "_hi"}, 64'(result_hi), 64'(exp_hi));
    chk({tag, "_flags"}, 64'(flags()), 64'(exp_fl));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({result_lo, result_hi, flags()} != '0), 64'd0);
    chk("reset_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    single("and", 4'b0000, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0, 32'h0, 7'b1000001);
    single("or", 4'b0001, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 32'h0, 7'b0000001);
    single("nor", 4'b1100, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0, 32'h0, 7'b1000001);
    single("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 7'b0010001);
    single("add_cout", 4'b0010, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'h0, 7'b0100001);
    single("sub", 4'b0110, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 32'h0, 7'b0000001);
    single("slt_lt", 4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h1, 32'h0, 7'b0000001);
    single("slt_ge", 4'b0111, 32'h00000001, 32'hFFFFFFFF, 32'h0, 32'h0, 7'b1000001);
    @(posedge clk);
    #1;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("hold_lo", 64'(result_lo), 64'd0);

    // MULU with a stray start mid-operation that must be ignored.
    issue(4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("mul_busy", 64'({busy, done}), 64'b10);
    chk("mul_state", 64'(dbg_state), 64'd1);
    chk("mul_hold_lo", 64'(result_lo), 64'd0);
    wait_done(5, lat);
    chk("mul_latency", 64'(lat), 64'd32);
    chk("mul_lo", 64'(result_lo), 64'h00000001);
    chk("mul_hi", 64'(result_hi), 64'hFFFFFFFE);
    chk("mul_flags", 64'(flags()), 64'(7'b0000001));
    @(posedge clk);
    #1;
    chk("mul_no_extra_done", 64'({busy, done}), 64'd0);

    issue(4'b1001, 32'd100, 32'd7);
    chk("div_busy", 64'(busy), 64'd1);
    wait_done(-1, lat);
    chk("div_latency", 64'(lat), 64'd32);
    chk("div_quot", 64'(result_lo), 64'd14);
    chk("div_rem", 64'(result_hi), 64'd2);
    chk("div_flags", 64'(flags()), 64'(7'b0000001));

    // Back-to-back: accepted in the same cycle done is high.
    single("div_by_zero", 4'b1001, 32'd1234, 32'd0, 32'hFFFFFFFF, 32'd1234, 7'b0001001);
    single("illegal", 4'b0011, 32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0, 7'b1000101);
    single("flags_reload", 4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0, 7'b0000001);

    // Reset in the middle of a multiply.
    issue(4'b1000, 32'd3, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", 64'({result_lo, result_hi, flags()} != '0), 64'd0);
    chk("midreset_state", 64'(dbg_state), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("midreset_no_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) chk("stale_done_after_reset", 64'(done), 64'd0);
    end
    single("post_reset_add", 4'b0010, 32'd2, 32'd3, 32'd5, 32'd0, 7'b0000001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
